// File: rtl/decode_pkg.sv
// Shared decode definitions: opcode encoding, instruction field positions,
// and per-opcode register-usage helpers used by the decode stage and its
// hazard unit.
package decode_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_ADDI = 4'd4,
        OP_LW   = 4'd5,
        OP_SW   = 4'd6,
        OP_BEQ  = 4'd7,
        OP_NOP  = 4'd15
    } opcode_e;

    localparam int INSTR_W = 32;
    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 28;
    localparam int RD_MSB  = 27;
    localparam int RD_LSB  = 24;
    localparam int RS1_MSB = 23;
    localparam int RS1_LSB = 20;
    localparam int RS2_MSB = 19;
    localparam int RS2_LSB = 16;
    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 0;
    localparam int IMM_W   = IMM_MSB - IMM_LSB + 1;

    // Map a raw opcode field onto a legal opcode; undefined encodings issue as NOP.
    function automatic opcode_e decode_opcode(input logic [3:0] raw);
        if (raw <= 4'd7) return opcode_e'(raw);
        return OP_NOP;
    endfunction

    function automatic logic uses_rs1(input opcode_e op);
        return op != OP_NOP;
    endfunction

    function automatic logic uses_rs2(input opcode_e op);
        return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SW, OP_BEQ};
    endfunction

    function automatic logic writes_rd(input opcode_e op);
        return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_LW};
    endfunction

endpackage

// File: rtl/decode_hazard.sv
// Combinational hazard detection and operand selection for the decode stage.
// A load in EX whose destination matches a used source register stalls decode.
// Writeback handling depends on DECODE_WB_BYPASS_EN: when defined, a same-cycle
// register-file write is forwarded to the operands; otherwise a matching write
// stalls for one cycle so the next cycle reads the updated register file.
module decode_hazard
    import decode_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 4
) (
    input  logic              if_valid,
    input  opcode_e           op,
    input  logic [REG_AW-1:0] rs1,
    input  logic [REG_AW-1:0] rs2,
    input  logic              ex_load,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              wb_we,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [DATA_W-1:0] rf_rd_data1,
    input  logic [DATA_W-1:0] rf_rd_data2,
    output logic              hazard,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b
);

    logic rs1_used;
    logic rs2_used;
    logic load_hz;
    logic wb_hit1;
    logic wb_hit2;

    assign rs1_used = if_valid && uses_rs1(op);
    assign rs2_used = if_valid && uses_rs2(op);
    assign wb_hit1  = wb_we && (wb_addr == rs1);
    assign wb_hit2  = wb_we && (wb_addr == rs2);
    assign load_hz  = ex_load && ((rs1_used && (ex_rd == rs1)) ||
                                  (rs2_used && (ex_rd == rs2)));

`ifdef DECODE_WB_BYPASS_EN
    // Forward the in-flight writeback value; only load-use stalls.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        hazard = load_hz;
        op_a   = rf_rd_data1;
        op_b   = rf_rd_data2;
        if (wb_hit1) op_a = wb_data;
        if (wb_hit2) op_b = wb_data;
    end
`else
    // Writeback data is not forwarded in this build; the stall covers it.
    logic unused_wb_data;
    assign unused_wb_data = ^wb_data;

    // Stall on load-use or on a same-cycle write to a used source.
    always_comb begin
        hazard = load_hz || (rs1_used && wb_hit1) || (rs2_used && wb_hit2);
        op_a   = rf_rd_data1;
        op_b   = rf_rd_data2;
    end
`endif

endmodule

// File: rtl/decode_stage.sv
// Instruction decode stage: splits the fetched instruction into fields,
// drives register-file read addresses, resolves hazards/operands through
// decode_hazard, and registers the result into the ID/EX outputs.
// Optional feature: define DECODE_WB_BYPASS_EN to forward writeback data
// instead of stalling one cycle on a writeback match.
module decode_stage
    import decode_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               if_valid,
    input  logic [INSTR_W-1:0] if_instr,
    input  logic [DATA_W-1:0]  if_pc,
    output logic               id_ready,
    output logic [REG_AW-1:0]  rf_rd_addr1,
    output logic [REG_AW-1:0]  rf_rd_addr2,
    input  logic [DATA_W-1:0]  rf_rd_data1,
    input  logic [DATA_W-1:0]  rf_rd_data2,
    input  logic               wb_we,
    input  logic [REG_AW-1:0]  wb_addr,
    input  logic [DATA_W-1:0]  wb_data,
    input  logic               ex_load,
    input  logic [REG_AW-1:0]  ex_rd,
    input  logic               flush,
    output logic               idex_valid,
    output logic [3:0]         idex_op,
    output logic [REG_AW-1:0]  idex_rd,
    output logic               idex_we,
    output logic [DATA_W-1:0]  idex_a,
    output logic [DATA_W-1:0]  idex_b,
    output logic [DATA_W-1:0]  idex_imm,
    output logic [DATA_W-1:0]  idex_pc
);

    opcode_e           op;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [IMM_W-1:0]  imm;
    logic [DATA_W-1:0] imm_ext;
    logic              hazard;
    logic              bubble;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;

    assign op      = decode_opcode(if_instr[OPC_MSB:OPC_LSB]);
    assign rd      = if_instr[RD_LSB  +: REG_AW];
    assign rs1     = if_instr[RS1_LSB +: REG_AW];
    assign rs2     = if_instr[RS2_LSB +: REG_AW];
    assign imm     = if_instr[IMM_MSB:IMM_LSB];
    assign imm_ext = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};

    // Read addresses follow the instruction word even when it is not valid.
    assign rf_rd_addr1 = rs1;
    assign rf_rd_addr2 = rs2;

    // A flush discards the instruction anyway, so it overrides any stall.
    assign id_ready = flush || !hazard;
    assign bubble   = flush || hazard;

    decode_hazard #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) u_hazard (
        .if_valid    (if_valid),
        .op          (op),
        .rs1         (rs1),
        .rs2         (rs2),
        .ex_load     (ex_load),
        .ex_rd       (ex_rd),
        .wb_we       (wb_we),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .rf_rd_data1 (rf_rd_data1),
        .rf_rd_data2 (rf_rd_data2),
        .hazard      (hazard),
        .op_a        (op_a),
        .op_b        (op_b)
    );

    // ID/EX pipeline register; a stall or flush inserts a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex_valid <= 1'b0;
            idex_op    <= '0;
            idex_rd    <= '0;
            idex_we    <= 1'b0;
            idex_a     <= '0;
            idex_b     <= '0;
            idex_imm   <= '0;
            idex_pc    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            idex_op  <= op;
            idex_rd  <= rd;
            idex_a   <= op_a;
            idex_b   <= op_b;
            idex_imm <= imm_ext;
            idex_pc  <= if_pc;
            if (bubble) begin
                idex_valid <= 1'b0;
                idex_we    <= 1'b0;
            end else begin
                idex_valid <= if_valid;
                idex_we    <= if_valid && writes_rd(op);
            end
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage with a small register-file
// model. Expectations track DECODE_WB_BYPASS_EN when it is defined.
module tb_decode_stage;

    localparam int DATA_W = 32;
    localparam int REG_AW = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              if_valid;
    logic [31:0]       if_instr;
    logic [DATA_W-1:0] if_pc;
    logic              id_ready;
    logic [REG_AW-1:0] rf_rd_addr1;
    logic [REG_AW-1:0] rf_rd_addr2;
    logic [DATA_W-1:0] rf_rd_data1;
    logic [DATA_W-1:0] rf_rd_data2;
    logic              wb_we;
    logic [REG_AW-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              ex_load;
    logic [REG_AW-1:0] ex_rd;
    logic              flush;
    logic              idex_valid;
    logic [3:0]        idex_op;
    logic [REG_AW-1:0] idex_rd;
    logic              idex_we;
    logic [DATA_W-1:0] idex_a;
    logic [DATA_W-1:0] idex_b;
    logic [DATA_W-1:0] idex_imm;
    logic [DATA_W-1:0] idex_pc;

    logic [DATA_W-1:0] rf [16];
    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    decode_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .id_ready    (id_ready),
        .rf_rd_addr1 (rf_rd_addr1),
        .rf_rd_addr2 (rf_rd_addr2),
        .rf_rd_data1 (rf_rd_data1),
        .rf_rd_data2 (rf_rd_data2),
        .wb_we       (wb_we),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .ex_load     (ex_load),
        .ex_rd       (ex_rd),
        .flush       (flush),
        .idex_valid  (idex_valid),
        .idex_op     (idex_op),
        .idex_rd     (idex_rd),
        .idex_we     (idex_we),
        .idex_a      (idex_a),
        .idex_b      (idex_b),
        .idex_imm    (idex_imm),
        .idex_pc     (idex_pc)
    );

    // Register-file model: asynchronous read, write on the rising edge.
    assign rf_rd_data1 = rf[rf_rd_addr1];
    assign rf_rd_data2 = rf[rf_rd_addr2];
    always @(posedge clk) if (wb_we) rf[wb_addr] <= wb_data;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Advance past the next rising edge and sample away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc);
        if_valid = v;
        if_instr = instr;
        if_pc    = pc;
    endtask

    // Instruction words: {opcode, rd, rs1, rs2, imm16}
    localparam logic [31:0] ADD_R3_R1_R2  = 32'h0312_0000;
    localparam logic [31:0] ADDI_R4_R1_M1 = 32'h4410_FFFF;
    localparam logic [31:0] ADDI_R5_R2_3  = 32'h4526_0003;
    localparam logic [31:0] OPC_C         = 32'hC512_0000;
    localparam logic [31:0] NOP_RS1_1     = 32'hF010_0000;

    initial begin
        for (int i = 0; i < 16; i++) rf[i] = 32'h100 + i;
        rf[1] = 32'd5;
        rf[2] = 32'd7;
        rst_n = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        wb_we = 1'b0; wb_addr = '0; wb_data = '0;
        ex_load = 1'b0; ex_rd = '0; flush = 1'b0;

        // Reset state
        #3;
        check("rst_valid", {31'd0, idex_valid}, 32'd0);
        check("rst_we", {31'd0, idex_we}, 32'd0);
        check("rst_a", idex_a, 32'd0);
        check("rst_ready", {31'd0, id_ready}, 32'd1);

        @(negedge clk);
        rst_n = 1'b1;

        // ADD r3,r1,r2 with r1=5, r2=7
        drive(1'b1, ADD_R3_R1_R2, 32'h0000_1000);
        #1;
        check("add_raddr1", {28'd0, rf_rd_addr1}, 32'd1);
        check("add_raddr2", {28'd0, rf_rd_addr2}, 32'd2);
        check("add_ready", {31'd0, id_ready}, 32'd1);
        step();
        check("add_valid", {31'd0, idex_valid}, 32'd1);
        check("add_a", idex_a, 32'd5);
        check("add_b", idex_b, 32'd7);
        check("add_we", {31'd0, idex_we}, 32'd1);
        check("add_rd", {28'd0, idex_rd}, 32'd3);
        check("add_op", {28'd0, idex_op}, 32'd0);
        check("add_pc", idex_pc, 32'h0000_1000);

        // Load-use on rs2
        ex_load = 1'b1; ex_rd = 4'd2;
        drive(1'b1, ADD_R3_R1_R2, 32'h0000_1004);
        #1;
        check("lu_ready", {31'd0, id_ready}, 32'd0);
        step();
        check("lu_valid", {31'd0, idex_valid}, 32'd0);
        check("lu_we", {31'd0, idex_we}, 32'd0);
        ex_load = 1'b0;
        #1;
        check("lu_ready_after", {31'd0, id_ready}, 32'd1);
        step();
        check("lu_issue_valid", {31'd0, idex_valid}, 32'd1);
        check("lu_issue_b", idex_b, 32'd7);

        // Writeback match on rs1: ADDI r4,r1,-1 with r1 being written to 0xAA
        wb_we = 1'b1; wb_addr = 4'd1; wb_data = 32'hAA;
        drive(1'b1, ADDI_R4_R1_M1, 32'h0000_1008);
`ifdef DECODE_WB_BYPASS_EN
        #1;
        check("wb_ready", {31'd0, id_ready}, 32'd1);
        step();
        wb_we = 1'b0;
`else
        #1;
        check("wb_ready", {31'd0, id_ready}, 32'd0);
        step();
        check("wb_bubble_valid", {31'd0, idex_valid}, 32'd0);
        wb_we = 1'b0;
        #1;
        check("wb_ready_after", {31'd0, id_ready}, 32'd1);
        step();
`endif
        check("wb_valid", {31'd0, idex_valid}, 32'd1);
        check("wb_a", idex_a, 32'hAA);
        check("wb_imm", idex_imm, 32'hFFFF_FFFF);
        check("wb_we_out", {31'd0, idex_we}, 32'd1);

        // Flush during a load-use hazard
        ex_load = 1'b1; ex_rd = 4'd1; flush = 1'b1;
        drive(1'b1, ADD_R3_R1_R2, 32'h0000_100C);
        #1;
        check("fl_ready", {31'd0, id_ready}, 32'd1);
        step();
        check("fl_valid", {31'd0, idex_valid}, 32'd0);
        check("fl_we", {31'd0, idex_we}, 32'd0);
        flush = 1'b0; ex_load = 1'b0;

        // Undefined opcode 0xC issues as NOP
        drive(1'b1, OPC_C, 32'h0000_1010);
        step();
        check("opc_c_op", {28'd0, idex_op}, 32'd15);
        check("opc_c_we", {31'd0, idex_we}, 32'd0);
        check("opc_c_valid", {31'd0, idex_valid}, 32'd1);

        // ADDI ignores rs2, so a load to that field is no hazard
        ex_load = 1'b1; ex_rd = 4'd6;
        drive(1'b1, ADDI_R5_R2_3, 32'h0000_1014);
        #1;
        check("addi_ready", {31'd0, id_ready}, 32'd1);
        step();
        check("addi_a", idex_a, 32'd7);
        check("addi_imm", idex_imm, 32'd3);
        check("addi_rd", {28'd0, idex_rd}, 32'd5);

        // NOP uses no source registers
        ex_rd = 4'd1;
        drive(1'b1, NOP_RS1_1, 32'h0000_1018);
        #1;
        check("nop_ready", {31'd0, id_ready}, 32'd1);
        step();
        check("nop_we", {31'd0, idex_we}, 32'd0);

        // Invalid input is a bubble with no hazard
        drive(1'b0, ADD_R3_R1_R2, 32'h0000_101C);
        #1;
        check("inv_ready", {31'd0, id_ready}, 32'd1);
        step();
        check("inv_valid", {31'd0, idex_valid}, 32'd0);
        check("inv_we", {31'd0, idex_we}, 32'd0);
        ex_load = 1'b0;

        // Reset asserted between edges clears outputs immediately
        drive(1'b1, ADD_R3_R1_R2, 32'h0000_1020);
        step();
        check("pre_rst_valid", {31'd0, idex_valid}, 32'd1);
        check("pre_rst_a", idex_a, 32'hAA);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {31'd0, idex_valid}, 32'd0);
        check("mid_rst_op", {28'd0, idex_op}, 32'd0);
        check("mid_rst_rd", {28'd0, idex_rd}, 32'd0);
        check("mid_rst_we", {31'd0, idex_we}, 32'd0);
        check("mid_rst_a", idex_a, 32'd0);
        check("mid_rst_b", idex_b, 32'd0);
        check("mid_rst_imm", idex_imm, 32'd0);
        check("mid_rst_pc", idex_pc, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, datapath and register width.
REQ-002 SHALL have parameter REG_AW, default 4, register address width (16 registers).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports if_valid  input  1, if_instr  input  32, and if_pc  input  DATA_W, carrying the fetched instruction.
REQ-006 SHALL have port id_ready  output  1  stage accepts if_instr this cycle.
REQ-007 SHALL have ports rf_rd_addr1, rf_rd_addr2  output  REG_AW  register-file read addresses.
REQ-008 SHALL have ports rf_rd_data1, rf_rd_data2  input  DATA_W  asynchronous register-file read data.
REQ-009 SHALL have ports wb_we  input  1, wb_addr  input  REG_AW, and wb_data  input  DATA_W, mirroring the register-file write port.
REQ-010 SHALL have ports ex_load  input  1 and ex_rd  input  REG_AW, identifying a valid load in EX and its destination.
REQ-011 SHALL have port flush  input  1  kill the decode output (taken branch).
REQ-012 SHALL have registered outputs idex_valid 1, idex_op 4, idex_rd REG_AW, idex_we 1, idex_a DATA_W, idex_b DATA_W, idex_imm DATA_W, and idex_pc DATA_W.

Function
REQ-013 SHALL decode fields opcode=[31:28], rd=[27:24], rs1=[23:20], rs2=[19:16], imm=[15:0], with imm sign-extended to DATA_W.
REQ-014 SHALL drive rf_rd_addr1=rs1 and rf_rd_addr2=rs2 combinationally from if_instr regardless of if_valid.
REQ-015 SHALL use opcodes ADD=0, SUB=1, AND=2, OR=3, ADDI=4, LW=5, SW=6, BEQ=7, NOP=15; any other opcode SHALL issue as NOP (idex_we=0, idex_op=15).
REQ-016 SHALL treat rs1 as used for every opcode except NOP; SHALL treat rs2 as used for ADD/SUB/AND/OR/SW/BEQ only.
REQ-017 SHALL set idex_we=1 for opcodes 0-5 and 0 otherwise.
REQ-018 SHALL flag a load-use hazard when if_valid, ex_load, and ex_rd equals a used source register.
REQ-019 SHALL, on a hazard, drive id_ready=0 and load a bubble (idex_valid=0, idex_we=0) while holding the instruction upstream.
REQ-020 SHALL take operands from wb_data instead of rf_rd_dataN when wb_we=1 and wb_addr equals the corresponding source register; register 0 is not special.
REQ-021 SHALL otherwise register the decoded instruction with idex_valid=if_valid, a latency of 1 cycle.
REQ-022 SHALL give flush priority over the hazard: next cycle idex_valid=0, idex_we=0, and id_ready=1.
REQ-023 SHALL treat if_valid=0 as a bubble, with id_ready=1 and no hazard.

Reset
REQ-024 SHALL, while rst_n=0, clear all idex_* outputs to 0 immediately, independent of clk.
REQ-025 SHALL drive id_ready=1 out of reset; the first accepted instruction SHALL appear on idex_* one cycle after the first clk edge with rst_n=1.

Configuration
REQ-026 SHALL provide the WB bypass of REQ-020 only when macro DECODE_WB_BYPASS_EN is defined.
REQ-027 SHALL, without DECODE_WB_BYPASS_EN, treat a wb match on a used source as a one-cycle hazard per REQ-019, then read the updated register file.

Structure
REQ-028 SHALL place the opcode enum, field bit positions, and the uses_rs1/uses_rs2/writes_rd helper functions in shared package decode_pkg.
REQ-029 SHALL implement hazard and bypass comparison in one combinational sub-module, decode_hazard.

Verification
REQ-030 SHALL cover: ADD r3,r1,r2 with r1=5, r2=7 -> next cycle idex_a=5, idex_b=7, idex_we=1, idex_rd=3.
REQ-031 SHALL cover: ex_load=1, ex_rd=2, decode ADD r3,r1,r2 -> id_ready=0 and idex_valid=0 for one cycle; after ex_load drops, ADD issues.
REQ-032 SHALL cover: wb_we=1, wb_addr=1, wb_data=0xAA, decode ADDI r4,r1,-1 -> idex_a=0xAA and idex_imm=0xFFFFFFFF (without the macro: one bubble, then idex_a=0xAA).
REQ-033 SHALL cover: flush=1 during a load-use hazard -> idex_valid=0 and id_ready=1 in the same cycle.
REQ-034 SHALL cover: opcode 0xC -> idex_op=15 and idex_we=0.
REQ-035 SHALL cover: rst_n dropped mid-stream between clk edges -> all idex_* read 0 immediately.
